l2_ifill: RTL and testbench
===========================

// Module: l2_ifill
// PURPOSE
//  Serves the fetch stage's L1I miss reads: accepts a line request (L2_read_en/L2_addr_read),
//  refills one 256-bit line from the MEM_W-bit memory bus in ascending beats and returns it
//  on L2_block_read while dropping L2_stall. Sits directly upstream of fetch. Keeps a 1-line
//  buffer so a repeat request for the same line returns without a bus transaction.
// PARAMETERS
//  MEM_W   64   memory read-data width; BEATS = 256/MEM_W (64 -> 4 beats)
//  ADDR_W  32   byte address width
// PORTS
//  clk            in   1       clock, all logic on posedge
//  rst_n          in   1       asynchronous active-low reset
//  L2_read_en     in   1       fetch requests the line holding L2_addr_read
//  L2_addr_read   in   ADDR_W  byte address; bits [4:0] ignored (line = addr[ADDR_W-1:5])
//  L2_block_read  out  256     line data, little endian: [31:0] = word at line offset 0
//  L2_stall       out  1       0 = L2_block_read valid for the current request; else 1
//  mem_req        out  1       memory read request, held until mem_gnt
//  mem_addr       out  ADDR_W  line base address {line,5'b0}, stable while mem_req=1
//  mem_gnt        in   1       memory accepts request this cycle (mem_req & mem_gnt)
//  mem_rvalid     in   1       one read beat valid on mem_rdata
//  mem_rdata      in   MEM_W   beat data; beat k -> L2_block_read[k*MEM_W +: MEM_W]
// BEHAVIOUR
//  Reset: state IDLE, L2_stall=1, mem_req=0, mem_addr=0, L2_block_read=0, buffer invalid,
//   beat count 0. Reset mid-refill discards all progress; beats arriving later are ignored.
//  States: IDLE, REQ, BEAT, DONE, DRAIN.
//  IDLE: L2_stall=1 unless serving a hit. On L2_read_en=1: latch line; if buffer valid and
//   tags equal -> DONE next cycle (1-cycle hit); else -> REQ, mem_req=1 from next cycle.
//  REQ: mem_req=1, mem_addr=latched base. On mem_gnt -> BEAT, count=0, mem_req=0 next cycle.
//  BEAT: each mem_rvalid writes beat[count], count++; gaps between beats allowed. After
//   beat BEATS-1: buffer valid, tag=latched line -> DONE. mem_rvalid outside BEAT/DRAIN ignored.
//  DONE: L2_stall=0 for exactly this cycle, L2_block_read=buffer; -> IDLE. L2_block_read
//   holds the last line afterwards (no clearing).
//  Miss latency with mem_gnt on first mem_req cycle and back-to-back beats: request at
//   cycle 0 -> mem_req cycle 1 -> beats cycles 2..5 -> L2_stall=0 at cycle 6.
//  Abort: in REQ, if L2_read_en=0 or line of L2_addr_read != latched line, drop mem_req
//   (no grant yet) and -> IDLE. In BEAT the memory cannot be cancelled: -> DRAIN, buffer
//   marked invalid; DRAIN counts remaining beats, discards them, then -> IDLE and the
//   current request (if any) is re-evaluated there. Simultaneous mem_gnt and abort in REQ:
//   grant wins, -> DRAIN.
//  Buffer written only by a complete, non-aborted refill; partial lines never visible.
//  Beat counter width $clog2(BEATS); no wrap (state exits at BEATS-1).
// TESTING
//  1 Reset, L2_read_en=1 addr 0, mem_gnt=1, beats 64'h1_00000000.. -> mem_addr=0,
//    L2_stall=0 exactly at cycle 6 with [31:0]=0, [63:32]=1; back to 1 next cycle.
//  2 Repeat request addr 0x14 after test 1 -> no mem_req, L2_stall=0 next cycle, same line.
//  3 Addr 964 (0x3C4), beats {33333333_22222222,...,99999999_88888888} -> mem_addr=0x3C0,
//    L2_block_read[63:32]=32'h33333333, [255:224]=32'h99999999.
//  4 mem_gnt withheld 5 cycles, mem_rvalid gaps of 2 -> mem_req/mem_addr stable; one DONE.
//  5 After grant for 0x100, switch addr to 0x200 after beat 1 -> remaining 2 beats drained,
//    then mem_req for 0x200; 0x100 data never returned, later 0x100 request misses.
//  6 rst_n low mid-BEAT -> all outputs at reset values async; stray mem_rvalid ignored.

Source files
------------

// File: rtl/l2_ifill.sv
// l2_ifill: L2 instruction-fill engine sitting directly upstream of fetch.
// Accepts L1I miss line requests, refills one 256-bit line from the memory
// read bus in ascending beats, and returns it to fetch. A one-line buffer
// serves a repeat request for the same line without a bus transaction.
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   L2_read_en      fetch requests the line holding L2_addr_read
//   L2_addr_read    byte address; bits [4:0] ignored
//   L2_block_read   256-bit line, word 0 in [31:0]; holds the last line returned
//   L2_stall        0 for exactly one cycle when L2_block_read answers the request
//   mem_req         memory read request, held until mem_gnt
//   mem_addr        line base address, stable while mem_req is high
//   mem_gnt         memory accepts the request this cycle
//   mem_rvalid      one read beat valid on mem_rdata
//   mem_rdata       beat data; beat k fills line bits [k*MEM_W +: MEM_W]
module l2_ifill #(
  parameter int MEM_W  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              L2_read_en,
  input  logic [ADDR_W-1:0] L2_addr_read,
  output logic [255:0]      L2_block_read,
  output logic              L2_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [MEM_W-1:0]  mem_rdata
);

  localparam int BEATS  = 256 / MEM_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W = ADDR_W - 5;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BEAT,
    DONE,
    DRAIN
  } state_e;

  state_e                        state_q, state_d;
  logic [LINE_W-1:0]             line_q;
  logic [CNT_W-1:0]              count_q;
  logic                          buf_valid_q;
  logic [LINE_W-1:0]             buf_tag_q;
  logic [255:0]                  buf_data_q;
  logic [BEATS-1:0][MEM_W-1:0]   fill_q;
  logic [BEATS-1:0][MEM_W-1:0]   fill_next;

  logic [LINE_W-1:0] req_line;
  logic              abort;
  logic              last;
  logic              line_ld, cnt_clr, cnt_inc, beat_we, fill_done, buf_inv;

  assign req_line = L2_addr_read[ADDR_W-1:5];
  // A refill belongs to the request only while fetch keeps asking for that line.
  assign abort    = !L2_read_en || (req_line != line_q);
  assign last     = (count_q == LAST_BEAT);

  assign mem_addr      = {line_q, 5'b0};
  assign L2_block_read = buf_data_q;

  // Staging line with the current beat merged in; becomes the buffer only
  // when the final beat of an unaborted refill arrives.
  always_comb begin
    fill_next          = fill_q;
    fill_next[count_q] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    line_ld   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    beat_we   = 1'b0;
    fill_done = 1'b0;
    buf_inv   = 1'b0;
    mem_req   = 1'b0;
    L2_stall  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (L2_read_en) begin
          line_ld = 1'b1;
          if (buf_valid_q && (buf_tag_q == req_line)) state_d = DONE;
          else                                        state_d = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          // Once granted the beats will come; an abort now must drain them.
          cnt_clr = 1'b1;
          if (abort) begin
            buf_inv = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = BEAT;
          end
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      BEAT: begin
        if (abort) begin
          buf_inv = 1'b1;
          if (mem_rvalid && last) begin
            state_d = IDLE;
          end else begin
            cnt_inc = mem_rvalid;
            state_d = DRAIN;
          end
        end else if (mem_rvalid) begin
          beat_we = 1'b1;
          if (last) begin
            fill_done = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (mem_rvalid) begin
          if (last) state_d = IDLE;
          else      cnt_inc = 1'b1;
        end
      end
      DONE: begin
        L2_stall = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q      <= '0;
      count_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      if (line_ld) line_q <= req_line;
      if (cnt_clr)      count_q <= '0;
      else if (cnt_inc) count_q <= count_q + 1'b1;
      if (fill_done) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= line_q;
        buf_data_q  <= fill_next;
      end else if (buf_inv) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the staging line is pure data gated by the FSM and never observed
  // before it is fully written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (beat_we) fill_q <= fill_next;
  end

endmodule

// File: tb/tb_l2_ifill.sv
// tb_l2_ifill: directed self-checking bench for l2_ifill. Inputs are driven
// 1 time unit after each rising edge and outputs are checked at that point,
// so every check sees the state produced by the preceding edge.
module tb_l2_ifill;

  logic           clk;
  logic           rst_n;
  logic           L2_read_en;
  logic [31:0]    L2_addr_read;
  logic [255:0]   L2_block_read;
  logic           L2_stall;
  logic           mem_req;
  logic [31:0]    mem_addr;
  logic           mem_gnt;
  logic           mem_rvalid;
  logic [63:0]    mem_rdata;

  int errors = 0;
  int checks = 0;

  l2_ifill #(.MEM_W(64), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .L2_read_en    (L2_read_en),
    .L2_addr_read  (L2_addr_read),
    .L2_block_read (L2_block_read),
    .L2_stall      (L2_stall),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] LINE_T1 = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
  localparam logic [255:0] LINE_T3 = {64'h99999999_88888888, 64'h77777777_66666666,
                                      64'h55555555_44444444, 64'h33333333_22222222};
  localparam logic [255:0] LINE_T4 = {64'h44440007_44440006, 64'h44440005_44440004,
                                      64'h44440003_44440002, 64'h44440001_44440000};
  localparam logic [255:0] LINE_T5 = {64'h20000007_20000006, 64'h20000005_20000004,
                                      64'h20000003_20000002, 64'h20000001_20000000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read beat presented for exactly one rising edge.
  task automatic beat(input logic [63:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    L2_read_en   = 1'b0;
    L2_addr_read = '0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    #12;
    chk("reset_stall", L2_stall, 1'b1);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_block", L2_block_read, 256'h0);
    rst_n = 1'b1;
    step();

    // Test 1: miss on line 0 with immediate grant and back-to-back beats.
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h0;
    mem_gnt      = 1'b1;
    step();                                   // cycle 1: REQ
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h0);
    chk("t1_stall_req", L2_stall, 1'b1);
    step();                                   // cycle 2: BEAT
    mem_gnt = 1'b0;
    chk("t1_req_dropped", mem_req, 1'b0);
    beat(64'h00000001_00000000);
    beat(64'h00000003_00000002);
    beat(64'h00000005_00000004);
    chk("t1_stall_cycle5", L2_stall, 1'b1);
    beat(64'h00000007_00000006);              // cycle 6: DONE
    chk("t1_stall_cycle6", L2_stall, 1'b0);
    chk("t1_word0", L2_block_read[31:0], 32'h0);
    chk("t1_word1", L2_block_read[63:32], 32'h1);
    chk("t1_line", L2_block_read, LINE_T1);
    L2_read_en = 1'b0;
    step();
    chk("t1_stall_after", L2_stall, 1'b1);
    chk("t1_hold_line", L2_block_read, LINE_T1);

    // Test 2: repeat request to the same line hits the buffer.
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h14;
    step();
    chk("t2_hit_stall", L2_stall, 1'b0);
    chk("t2_hit_no_req", mem_req, 1'b0);
    chk("t2_hit_line", L2_block_read, LINE_T1);
    L2_read_en = 1'b0;
    step();
    chk("t2_stall_after", L2_stall, 1'b1);

    // Test 3: unaligned address 0x3C4 refills line base 0x3C0.
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h3C4;
    mem_gnt      = 1'b1;
    step();
    chk("t3_mem_req", mem_req, 1'b1);
    chk("t3_mem_addr", mem_addr, 32'h3C0);
    step();
    mem_gnt = 1'b0;
    beat(64'h33333333_22222222);
    beat(64'h55555555_44444444);
    beat(64'h77777777_66666666);
    beat(64'h99999999_88888888);
    chk("t3_stall", L2_stall, 1'b0);
    chk("t3_word1", L2_block_read[63:32], 32'h33333333);
    chk("t3_word7", L2_block_read[255:224], 32'h99999999);
    chk("t3_line", L2_block_read, LINE_T3);
    L2_read_en = 1'b0;
    step();

    // Test 4: grant withheld 5 cycles, stray beat during REQ, gaps between beats.
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h40;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_req_held%0d", i), mem_req, 1'b1);
      chk($sformatf("t4_addr_held%0d", i), mem_addr, 32'h40);
      mem_rvalid = (i == 2);
      mem_rdata  = 64'hDEADBEEF_DEADBEEF;
      step();
      mem_rvalid = 1'b0;
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("t4_req_dropped", mem_req, 1'b0);
    step();
    step();
    beat(64'h44440001_44440000);
    step();
    step();
    beat(64'h44440003_44440002);
    chk("t4_stall_gap", L2_stall, 1'b1);
    step();
    step();
    beat(64'h44440005_44440004);
    step();
    step();
    beat(64'h44440007_44440006);
    chk("t4_done", L2_stall, 1'b0);
    chk("t4_line", L2_block_read, LINE_T4);
    L2_read_en = 1'b0;
    step();
    step();
    chk("t4_single_done", L2_stall, 1'b1);

    // Test 5: address changes mid-refill; remaining beats drained, new line fetched.
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h100;
    mem_gnt      = 1'b1;
    step();
    chk("t5_addr_100", mem_addr, 32'h100);
    step();
    mem_gnt = 1'b0;
    beat(64'h10000001_10000000);
    beat(64'h10000003_10000002);
    L2_addr_read = 32'h200;
    step();                                   // abort seen in BEAT -> DRAIN
    chk("t5_drain_no_req", mem_req, 1'b0);
    chk("t5_drain_stall", L2_stall, 1'b1);
    beat(64'h10000005_10000004);
    chk("t5_drain_mid_req", mem_req, 1'b0);
    beat(64'h10000007_10000006);              // last drained beat -> IDLE
    chk("t5_idle_stall", L2_stall, 1'b1);
    chk("t5_line_untouched", L2_block_read, LINE_T4);
    mem_gnt = 1'b1;
    step();
    chk("t5_new_req", mem_req, 1'b1);
    chk("t5_addr_200", mem_addr, 32'h200);
    step();
    mem_gnt = 1'b0;
    beat(64'h20000001_20000000);
    beat(64'h20000003_20000002);
    beat(64'h20000005_20000004);
    beat(64'h20000007_20000006);
    chk("t5_done_200", L2_stall, 1'b0);
    chk("t5_line_200", L2_block_read, LINE_T5);
    L2_read_en = 1'b0;
    step();
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h100;
    step();
    chk("t5_100_misses", mem_req, 1'b1);
    chk("t5_100_stall", L2_stall, 1'b1);
    L2_read_en = 1'b0;                        // abort before grant
    step();
    chk("t5_req_abort", mem_req, 1'b0);

    // Test 6: asynchronous reset in the middle of a refill.
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h300;
    mem_gnt      = 1'b1;
    step();
    step();
    mem_gnt = 1'b0;
    beat(64'h30000001_30000000);
    beat(64'h30000003_30000002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_stall", L2_stall, 1'b1);
    chk("t6_async_req", mem_req, 1'b0);
    chk("t6_async_addr", mem_addr, 32'h0);
    chk("t6_async_block", L2_block_read, 256'h0);
    #2;
    rst_n      = 1'b1;
    L2_read_en = 1'b0;
    step();
    beat(64'h30000005_30000004);
    beat(64'h30000007_30000006);
    chk("t6_stray_stall", L2_stall, 1'b1);
    chk("t6_stray_req", mem_req, 1'b0);
    chk("t6_stray_block", L2_block_read, 256'h0);
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h200;                   // buffered before reset, must miss now
    step();
    chk("t6_buf_invalid", mem_req, 1'b1);
    chk("t6_buf_addr", mem_addr, 32'h200);
    L2_read_en = 1'b0;
    step();
    chk("t6_final_idle", mem_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
